// File: rtl/fifo_dram_flex.sv
// Synchronous FIFO for DRAM command/data traffic.
// Ports: clk, rst (sync, active high), flush, wr_en/datain, rd_en/dataout/valid,
// full_flag, empty_flag, almost_full, almost_empty, count, overflow, underflow.
module fifo_dram_flex #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dataout,
  output logic                     valid,
  output logic                     full_flag,
  output logic                     empty_flag,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_dram_flex: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_dram_flex: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_dram_flex: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_dram_flex: AE_THRESH out of range 0..DEPTH-1");
  end
  if (FWFT > 1) begin : g_bad_fwft
    $error("fifo_dram_flex: FWFT must be 0 or 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full_flag    = (count == CW'(DEPTH));
  assign empty_flag   = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // Acceptance is decided from registered flags; no same-cycle bypass.
  assign wr_acc = wr_en && !full_flag;
  assign rd_acc = rd_en && !empty_flag;

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wr_ptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en && full_flag;
      underflow <= rd_en && empty_flag;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // Flush clears valid but leaves the last popped word on dataout.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
        valid_q <= rd_acc;
      end
    end

    assign dataout = dout_q;
    assign valid   = valid_q;
  end else begin : g_fwft
    assign dataout = mem[rd_ptr];
    assign valid   = !empty_flag;
  end

endmodule

// File: tb/tb_fifo_dram_flex.sv
module tb_fifo_dram_flex;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic        rst = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        vld, full, empty, af, ae, ovf, unf;
  logic [4:0]  cnt;

  fifo_dram_flex #(.WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr), .datain(din), .rd_en(rd),
    .dataout(dout), .valid(vld), .full_flag(full), .empty_flag(empty),
    .almost_full(af), .almost_empty(ae), .count(cnt), .overflow(ovf), .underflow(unf)
  );

  // FWFT instance
  logic        frst = 1'b0, fflush = 1'b0, fwr = 1'b0, frd = 1'b0;
  logic [31:0] fdin = '0;
  logic [31:0] fdout;
  logic        fvld, ffull, fempty, faf, fae, fovf, funf;
  logic [4:0]  fcnt;

  fifo_dram_flex #(.WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rst(frst), .flush(fflush), .wr_en(fwr), .datain(fdin), .rd_en(frd),
    .dataout(fdout), .valid(fvld), .full_flag(ffull), .empty_flag(fempty),
    .almost_full(faf), .almost_empty(fae), .count(fcnt), .overflow(fovf), .underflow(funf)
  );

  typedef struct {
    logic        rst, flush, wr, rd;
    logic [31:0] din;
    logic [4:0]  e_count;
    logic        e_valid, e_ovf, e_unf;
    logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, input logic f, input logic w, input logic d,
                              input logic [31:0] di, input int ec, input logic ev,
                              input logic eo, input logic eu, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.flush = f; v.wr = w; v.rd = d; v.din = di;
    v.e_count = 5'(ec); v.e_valid = ev; v.e_ovf = eo; v.e_unf = eu; v.e_data = ed;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic fstep(input logic r, input logic f, input logic w, input logic d, input logic [31:0] di);
    @(negedge clk);
    frst = r; fflush = f; fwr = w; frd = d; fdin = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ec;
    // Test 1: reset, fill 16, overflow
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 16; i++) add(0, 0, 1, 0, 32'hA0 + i, i + 1, 0, 0, 0, 32'h0);
    add(0, 0, 1, 0, 32'hEE, 16, 0, 1, 0, 32'h0);
    add(0, 0, 0, 0, 0, 16, 0, 0, 0, 32'h0);
    // Test 2: drain 16 in order, then underflow with dataout held
    for (int i = 0; i < 16; i++) add(0, 0, 0, 1, 0, 15 - i, 1, 0, 0, 32'hA0 + i);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hAF);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAF);
    // Test 3: fill 8, 20 simultaneous read/write across pointer wrap, drain
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 32'hB0 + i, i + 1, 0, 0, 0, 32'hAF);
    for (int k = 0; k < 20; k++) add(0, 0, 1, 1, 32'hB8 + k, 8, 1, 0, 0, 32'hB0 + k);
    for (int j = 0; j < 8; j++) add(0, 0, 0, 1, 0, 7 - j, 1, 0, 0, 32'hC4 + j);
    // Test 4: both on full -> pop only + overflow; both on empty -> push only + underflow
    for (int i = 0; i < 16; i++) add(0, 0, 1, 0, 32'hC0 + i, i + 1, 0, 0, 0, 32'hCB);
    add(0, 0, 1, 1, 32'hDD, 15, 1, 1, 0, 32'hC0);
    for (int i = 0; i < 15; i++) add(0, 0, 0, 1, 0, 14 - i, 1, 0, 0, 32'hC1 + i);
    add(0, 0, 1, 1, 32'hD1, 1, 0, 0, 1, 32'hCF);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0, 32'hD1);
    // Test 6: flush with write at count 10 discards the write
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 32'hE0 + i, i + 1, 0, 0, 0, 32'hD1);
    add(0, 1, 1, 0, 32'h77, 0, 0, 0, 0, 32'hD1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hD1);
    // Mid-burst reset with requests pending
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 32'hF0 + i, i + 1, 0, 0, 0, 32'hD1);
    add(0, 0, 1, 1, 32'hF3, 3, 1, 0, 0, 32'hF0);
    add(1, 0, 1, 1, 32'hF4, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; flush = vq[i].flush; wr = vq[i].wr; rd = vq[i].rd; din = vq[i].din;
      @(posedge clk);
      #1;
      ec = int'(vq[i].e_count);
      chk("count",        i, 32'(cnt),   32'(vq[i].e_count));
      chk("full_flag",    i, 32'(full),  32'(ec == 16));
      chk("empty_flag",   i, 32'(empty), 32'(ec == 0));
      chk("almost_full",  i, 32'(af),    32'(ec >= 14));
      chk("almost_empty", i, 32'(ae),    32'(ec <= 2));
      chk("valid",        i, 32'(vld),   32'(vq[i].e_valid));
      chk("overflow",     i, 32'(ovf),   32'(vq[i].e_ovf));
      chk("underflow",    i, 32'(unf),   32'(vq[i].e_unf));
      chk("dataout",      i, dout,       vq[i].e_data);
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0;

    // Test 5: FWFT fall-through and pop
    fstep(1, 0, 0, 0, 0);
    chk("fw_rst_valid", 0, 32'(fvld), 32'h0);
    chk("fw_rst_empty", 0, 32'(fempty), 32'h1);
    chk("fw_rst_count", 0, 32'(fcnt), 32'h0);
    fstep(0, 0, 1, 0, 32'h55);
    chk("fw_wr_data",  1, fdout, 32'h55);
    chk("fw_wr_valid", 1, 32'(fvld), 32'h1);
    chk("fw_wr_count", 1, 32'(fcnt), 32'h1);
    fstep(0, 0, 1, 0, 32'h66);
    chk("fw_head_hold", 2, fdout, 32'h55);
    chk("fw_count2",    2, 32'(fcnt), 32'h2);
    fstep(0, 0, 0, 1, 0);
    chk("fw_pop_data",  3, fdout, 32'h66);
    chk("fw_pop_valid", 3, 32'(fvld), 32'h1);
    fstep(0, 0, 0, 1, 0);
    chk("fw_last_valid", 4, 32'(fvld), 32'h0);
    chk("fw_last_empty", 4, 32'(fempty), 32'h1);
    fstep(0, 0, 0, 1, 0);
    chk("fw_underflow", 5, 32'(funf), 32'h1);
    chk("fw_uf_count",  5, 32'(fcnt), 32'h0);
    fstep(0, 0, 1, 0, 32'h99);
    fstep(0, 1, 1, 0, 32'hAA);
    chk("fw_flush_valid", 7, 32'(fvld), 32'h0);
    chk("fw_flush_count", 7, 32'(fcnt), 32'h0);
    fstep(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
